// File: rtl/spram_ctrl_pkg.sv
// Shared helpers for the single-port RAM round-robin controller.
// Latency: n/a (constants and combinational functions only).
// Backpressure: n/a.
package spram_ctrl_pkg;

    // Largest supported requester count; sizes the one-hot decoder input.
    localparam int MAX_REQ = 8;

    // Cycles from grant to rvalid: one issue register, the RAM's internal
    // read register, plus the optional address and output pipeline stages.
    function automatic int rd_latency(input int addr_pipe, input int dout_pipe);
        return 2 + addr_pipe + dout_pipe;
    endfunction

    // Index of the set bit in a one-hot (or all-zero) vector.
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last winner.
// Latency: combinational grant; pointer advances at the clock edge of a grant.
// Backpressure: en=0 or rst=1 forces gnt to zero.
//
// Ports: clk, rst (sync, active-high), en, req[NUM_REQ], gnt[NUM_REQ] (one-hot).
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = PW + 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic [CW-1:0] cand;
    logic          found;

    // Search ptr+1, ptr+2, ... wrapping at NUM_REQ; the winner is the first hit.
    always_comb begin
        gnt   = '0;
        gidx  = ptr;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, ptr} + CW'(k);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!found && en && !rst && req[cand[PW-1:0]]) begin
                found = 1'b1;
                gidx  = cand[PW-1:0];
            end
        end
        if (found) begin
            gnt[gidx] = 1'b1;
        end
    end

    // Reset to the last index so requester 0 has top priority first.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= PW'(NUM_REQ - 1);
        end else if (found) begin
            ptr <= gidx;
        end
    end

endmodule

// File: rtl/spram_rr_ctrl.sv
// Shares one single-port RAM among NUM_REQ requesters with round-robin arbitration.
// Latency: read data returns 2+ADDR_PIPE+DOUT_PIPE cycles after grant, tagged with rid.
// Backpressure: one grant per cycle via gnt; no backpressure on read return.
//
// Ports: clk/rst (sync, active-high); en gates new grants; req/req_we/req_addr/
// req_wdata per-requester commands (flattened slices); gnt one-hot accept;
// rvalid/rid/rdata read return; busy = any command in flight; ram_* drive and
// receive the RAM pins.
module spram_rr_ctrl #(
    parameter int NUM_REQ   = 2,
    parameter int ID_W      = 1,
    parameter int MEM_WIDTH = 16,
    parameter int ADD_SIZE  = 10,
    parameter int ADDR_PIPE = 0,
    parameter int DOUT_PIPE = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADD_SIZE-1:0]   req_addr,
    input  logic [NUM_REQ*MEM_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          rvalid,
    output logic [ID_W-1:0]               rid,
    output logic [MEM_WIDTH-1:0]          rdata,
    output logic                          busy,
    output logic [MEM_WIDTH-1:0]          ram_din,
    output logic [ADD_SIZE-1:0]           ram_addr,
    output logic                          ram_addr_en,
    output logic                          ram_wr_en,
    output logic                          ram_rd_en,
    output logic                          ram_blk_select,
    output logic                          ram_dout_en,
    input  logic [MEM_WIDTH-1:0]          ram_dout
);

    import spram_ctrl_pkg::*;

    // Tag pipeline depth equals the read latency; stage k holds the command
    // granted k+1 cycles ago, so stage ADDR_PIPE is the RAM execute stage.
    localparam int LAT = rd_latency(ADDR_PIPE, DOUT_PIPE);

    logic [NUM_REQ-1:0]   gnt_i;
    logic                 g_vld;
    logic [2:0]           g_idx;
    logic                 g_we;
    logic [ADD_SIZE-1:0]  g_addr;
    logic [MEM_WIDTH-1:0] g_wdata;

    logic [LAT-1:0]       vld_q;
    logic [LAT-1:0]       we_q;
    logic [ID_W-1:0]      id_q [LAT];
    logic [ADD_SIZE-1:0]  addr_q;
    logic [MEM_WIDTH-1:0] wdata_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .req (req),
        .gnt (gnt_i)
    );

    assign gnt   = gnt_i;
    assign g_vld = |gnt_i;
    assign g_idx = onehot_to_idx(MAX_REQ'(gnt_i));

    // Select the granted requester's command fields.
    always_comb begin
        g_we    = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_i[i]) begin
                g_we    = req_we[i];
                g_addr  = req_addr[i*ADD_SIZE +: ADD_SIZE];
                g_wdata = req_wdata[i*MEM_WIDTH +: MEM_WIDTH];
            end
        end
    end

    // Tag shift register: every accepted command enters; writes ride along
    // only so busy covers their issue stages, and never raise rvalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            we_q  <= '0;
            for (int k = 0; k < LAT; k++) begin
                id_q[k] <= '0;
            end
        end else begin
            vld_q   <= {vld_q[LAT-2:0], g_vld};
            we_q    <= {we_q[LAT-2:0], g_we};
            id_q[0] <= ID_W'(g_idx);
            for (int k = 1; k < LAT; k++) begin
                id_q[k] <= id_q[k-1];
            end
        end
    end

    // Address and write data hold their last value between commands; only
    // the strobes mark a cycle as active.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (g_vld) begin
            addr_q  <= g_addr;
            wdata_q <= g_wdata;
        end
    end

    // With an address-pipelined RAM, din must wait one more cycle to meet
    // the write strobe at the execute stage.
    generate
        if (ADDR_PIPE != 0) begin : g_apipe
            logic [MEM_WIDTH-1:0] wdata_e;
            always_ff @(posedge clk) begin
                if (rst) begin
                    wdata_e <= '0;
                end else begin
                    wdata_e <= wdata_q;
                end
            end
            assign ram_din = wdata_e;
        end else begin : g_noapipe
            assign ram_din = wdata_q;
        end
    endgenerate

    assign ram_addr       = addr_q;
    assign ram_addr_en    = vld_q[0];
    assign ram_blk_select = vld_q[ADDR_PIPE];
    assign ram_wr_en      = vld_q[ADDR_PIPE] &  we_q[ADDR_PIPE];
    assign ram_rd_en      = vld_q[ADDR_PIPE] & ~we_q[ADDR_PIPE];
    // Output register load, one cycle after the RAM's internal read register.
    assign ram_dout_en    = (DOUT_PIPE != 0) ? (vld_q[ADDR_PIPE+1] & ~we_q[ADDR_PIPE+1]) : 1'b0;

    assign rvalid = vld_q[LAT-1] & ~we_q[LAT-1];
    assign rid    = id_q[LAT-1];
    assign rdata  = ram_dout;
    assign busy   = |vld_q;

endmodule

// File: doc/spram_rr_ctrl.md
Name: spram_rr_ctrl

Overview:
Round-robin arbiter and sequencer that shares one single_port_Ram instance among NUM_REQ requesters.
- Accepts at most one read or write command per cycle.
- Drives every RAM control pin, aligning them to the RAM's address/dout pipeline configuration.
- Returns read data tagged with the requester ID at a fixed latency.
- Sits between client logic and the RAM; the RAM and this block share clk and rst.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ID_W, 1, requester ID width; must satisfy 2**ID_W >= NUM_REQ
MEM_WIDTH, 16, data width; must match RAM
ADD_SIZE, 10, address width; must match RAM
ADDR_PIPE, 0, 1 when the RAM is built with ADDR_PIPELINE="TRUE"
DOUT_PIPE, 1, 1 when the RAM is built with DOUT_PIPELINE="TRUE"

Ports:
- Clock and reset (already decided): one clock, `clk`; reset `rst` is synchronous and active-high.
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  when 0, no new grants; commands already in flight complete
req  in  NUM_REQ  per-requester command valid
req_we  in  NUM_REQ  per-requester 1=write, 0=read
req_addr  in  NUM_REQ*ADD_SIZE  flattened; requester i uses slice [i*ADD_SIZE +: ADD_SIZE]
req_wdata  in  NUM_REQ*MEM_WIDTH  flattened write data, same slicing rule
gnt  out  NUM_REQ  one-hot; command accepted in the cycle where req[i] and gnt[i] are both 1
rvalid  out  1  read data valid
rid  out  ID_W  requester index owning rdata
rdata  out  MEM_WIDTH  read data, passthrough of ram_dout
busy  out  1  any command in flight
ram_din  out  MEM_WIDTH  to RAM din
ram_addr  out  ADD_SIZE  to RAM addr
ram_addr_en  out  1  to RAM addr_en
ram_wr_en  out  1  to RAM wr_en
ram_rd_en  out  1  to RAM rd_en
ram_blk_select  out  1  to RAM blk_select
ram_dout_en  out  1  to RAM dout_en
ram_dout  in  MEM_WIDTH  from RAM dout

Behaviour:
Reset:
- All outputs 0; in-flight tags flushed; no rvalid after reset, even for reads issued before it.
- RR pointer set to NUM_REQ-1, so requester 0 has top priority first.

Arbitration (cycle t, combinational):
- If en=1 and req is non-zero, grant the first requester with req set, searching ptr+1, ptr+2, ... modulo NUM_REQ.
- gnt is 0 when en=0 or rst=1.
- ptr updates to the granted index at the clock edge.
- Throughput: one grant per cycle; a requester holding req continuously is granted every NUM_REQ cycles under full contention.

Issue:
- The granted command is registered at t+1 onto ram_addr with ram_addr_en=1.
- Stage E = t+1+ADDR_PIPE. At E: ram_blk_select=1, ram_wr_en=we, ram_rd_en=~we, ram_din=wdata (delayed one extra register when ADDR_PIPE=1).
- All RAM strobes are single-cycle pulses and are 0 when idle.

Read return:
- The RAM's internal register loads at the end of E.
- If DOUT_PIPE=1: ram_dout_en pulses at E+1, and rvalid/rid appear at E+2.
- If DOUT_PIPE=0: ram_dout_en=0, and rvalid/rid appear at E+1.
- Read latency from grant = 2+ADDR_PIPE+DOUT_PIPE cycles (default 3).
- rvalid is a single-cycle pulse per read; there is no backpressure.
- rdata is meaningful only while rvalid=1.

Tag tracking:
- A shift register of {valid, id}, depth 2+ADDR_PIPE+DOUT_PIPE.
- busy = OR of all valid bits, including issue stages.

Ordering and hazards:
- Commands execute in grant order.
- Write at E followed by a read of the same address at E+1 returns the new data.
- Writes produce no response.

Boundaries:
- A simultaneous req from all requesters gives a strict rotation.
- The RR pointer wraps from NUM_REQ-1 to 0.
- en dropping mid-burst stops grants next cycle; pending reads still return.
- rst mid-read: tags are cleared and no stale rvalid is produced.

Decomposition:
- Package spram_ctrl_pkg: read-latency constant function and onehot-to-index function.
- One sub-module, rr_arbiter: NUM_REQ req in, one-hot gnt out, internal pointer, sync reset.

Test Plan:
1. Reset/idle: rst=1 for 2 cycles, then req=0 -> all outputs 0, busy=0, no RAM strobe for 10 cycles.
2. Single write then read (defaults): req0 write addr=0x005 data=0xA5A5; next cycle req0 read addr=0x005 -> ram_wr_en pulse at t+1; rvalid=1, rid=0, rdata=0xA5A5 exactly 3 cycles after read grant.
3. Contention: req=2'b11 held for 6 cycles, all reads -> gnt sequence 01,10,01,10,01,10; six rvalid pulses in matching rid order 0,1,0,1,0,1.
4. Back-to-back hazard: write addr 0x3FF=0x1234 immediately followed by read 0x3FF from the other requester -> rdata=0x1234, rid=1.
5. Pipeline variants: ADDR_PIPE=1, DOUT_PIPE=1 -> read latency 4; ADDR_PIPE=0, DOUT_PIPE=0 -> latency 2; ram_dout_en=0 in the latter case.
6. Abort and gating: grant a read, assert rst one cycle later -> no rvalid ever for that read. Separately, en=0 with req=11 -> gnt=00 and busy drains to 0.
